// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// axi_rd_arbiter: round-robin arbiter sharing one AXI4 read port between the
// instruction-side (port 0) and data-side (port 1) masters, one burst in flight.
// Revision: 1.0
// ============================================================================
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ID_W-1:0]   s0_arid,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [7:0]        s0_arlen,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    input  logic [3:0]        s0_arcache,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [ID_W-1:0]   s0_rid,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic              s0_rvalid,
    input  logic              s0_rready,

    input  logic [ID_W-1:0]   s1_arid,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [7:0]        s1_arlen,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    input  logic [3:0]        s1_arcache,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [ID_W-1:0]   s1_rid,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              s1_rvalid,
    input  logic              s1_rready,

    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [3:0]        m_arcache,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,

    output logic              err_len,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic              r_grant;
    logic              r_last_grant;
    logic [7:0]        r_beat_cnt;
    logic              r_err_len;

    logic [ID_W-1:0]   r_m_arid;
    logic [ADDR_W-1:0] r_m_araddr;
    logic [7:0]        r_m_arlen;
    logic [2:0]        r_m_arsize;
    logic [1:0]        r_m_arburst;
    logic [3:0]        r_m_arcache;
    logic              r_m_arvalid;

    logic              w_req_any;
    logic              w_win;
    logic              w_ar_take;
    logic              w_ar_done;
    logic              w_beat;
    logic              w_beat_last;

    logic [ID_W-1:0]   w_sel_arid;
    logic [ADDR_W-1:0] w_sel_araddr;
    logic [7:0]        w_sel_arlen;
    logic [2:0]        w_sel_arsize;
    logic [1:0]        w_sel_arburst;
    logic [3:0]        w_sel_arcache;

    // Incoming ID MSBs are overwritten by the port index; returned MSB is ignored.
    logic              w_unused_id_msbs;
    assign w_unused_id_msbs = ^{m_rid[ID_W-1], s0_arid[ID_W-1], s1_arid[ID_W-1]};

    // Tie goes to the port that did not win last; a lone requester always wins.
    always_comb begin
        if (s0_arvalid && s1_arvalid) begin
            w_win = ~r_last_grant;
        end else begin
            w_win = s1_arvalid;
        end
    end

    assign w_req_any   = s0_arvalid | s1_arvalid;
    assign w_ar_take   = (r_state == S_IDLE) & w_req_any;
    assign w_ar_done   = (r_state == S_ADDR) & m_arready;
    assign w_beat      = (r_state == S_DATA) & m_rvalid & m_rready;
    assign w_beat_last = w_beat & m_rlast;

    always_comb begin
        if (w_win) begin
            w_sel_arid    = s1_arid;
            w_sel_araddr  = s1_araddr;
            w_sel_arlen   = s1_arlen;
            w_sel_arsize  = s1_arsize;
            w_sel_arburst = s1_arburst;
            w_sel_arcache = s1_arcache;
        end else begin
            w_sel_arid    = s0_arid;
            w_sel_araddr  = s0_araddr;
            w_sel_arlen   = s0_arlen;
            w_sel_arsize  = s0_arsize;
            w_sel_arburst = s0_arburst;
            w_sel_arcache = s0_arcache;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req_any)   w_state_nxt = S_ADDR;
            S_ADDR:  if (m_arready)   w_state_nxt = S_DATA;
            S_DATA:  if (w_beat_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        m_rready   = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                s0_arready = w_req_any & ~w_win;
                s1_arready = w_req_any & w_win;
            end
            S_DATA: begin
                if (r_grant) begin
                    s1_rvalid = m_rvalid;
                    m_rready  = s1_rready;
                end else begin
                    s0_rvalid = m_rvalid;
                    m_rready  = s0_rready;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_beat_cnt   <= 8'd0;
            r_err_len    <= 1'b0;
            r_m_arid     <= '0;
            r_m_araddr   <= '0;
            r_m_arlen    <= 8'd0;
            r_m_arsize   <= 3'd0;
            r_m_arburst  <= 2'd0;
            r_m_arcache  <= 4'd0;
            r_m_arvalid  <= 1'b0;
        end else begin
            if (w_ar_take) begin
                r_grant     <= w_win;
                r_m_arid    <= {w_win, w_sel_arid[ID_W-2:0]};
                r_m_araddr  <= w_sel_araddr;
                r_m_arlen   <= w_sel_arlen;
                r_m_arsize  <= w_sel_arsize;
                r_m_arburst <= w_sel_arburst;
                r_m_arcache <= w_sel_arcache;
                r_m_arvalid <= 1'b1;
            end
            if (w_ar_done) begin
                r_m_arvalid  <= 1'b0;
                r_beat_cnt   <= 8'd0;
                r_last_grant <= r_grant;
            end
            // Counter holds beats already taken, so beat index arlen must be the last.
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
                if (m_rlast != (r_beat_cnt == r_m_arlen)) begin
                    r_err_len <= 1'b1;
                end
            end
        end
    end

    assign m_arid    = r_m_arid;
    assign m_araddr  = r_m_araddr;
    assign m_arlen   = r_m_arlen;
    assign m_arsize  = r_m_arsize;
    assign m_arburst = r_m_arburst;
    assign m_arcache = r_m_arcache;
    assign m_arvalid = r_m_arvalid;
    assign err_len   = r_err_len;

    assign s0_rid   = {1'b0, m_rid[ID_W-2:0]};
    assign s0_rdata = m_rdata;
    assign s0_rresp = m_rresp;
    assign s0_rlast = m_rlast;
    assign s1_rid   = {1'b0, m_rid[ID_W-2:0]};
    assign s1_rdata = m_rdata;
    assign s1_rresp = m_rresp;
    assign s1_rlast = m_rlast;

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// tb_axi_rd_arbiter: directed and randomized bench for axi_rd_arbiter.
// Revision: 1.0
// ============================================================================
module tb_axi_rd_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    logic              clk;
    logic              reset;
    logic [ID_W-1:0]   s0_arid, s1_arid, m_arid;
    logic [ADDR_W-1:0] s0_araddr, s1_araddr, m_araddr;
    logic [7:0]        s0_arlen, s1_arlen, m_arlen;
    logic [2:0]        s0_arsize, s1_arsize, m_arsize;
    logic [1:0]        s0_arburst, s1_arburst, m_arburst;
    logic [3:0]        s0_arcache, s1_arcache, m_arcache;
    logic              s0_arvalid, s1_arvalid, m_arvalid;
    logic              s0_arready, s1_arready, m_arready;
    logic [ID_W-1:0]   s0_rid, s1_rid, m_rid;
    logic [DATA_W-1:0] s0_rdata, s1_rdata, m_rdata;
    logic [1:0]        s0_rresp, s1_rresp, m_rresp;
    logic              s0_rlast, s1_rlast, m_rlast;
    logic              s0_rvalid, s1_rvalid, m_rvalid;
    logic              s0_rready, s1_rready, m_rready;
    logic              err_len, busy;

    int   n_checks;
    int   n_err;
    logic exp_last;   // model: port granted by the most recent accepted burst

    axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
        .s0_arburst(s0_arburst), .s0_arcache(s0_arcache), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
        .s1_arburst(s1_arburst), .s1_arcache(s1_arcache), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arcache(m_arcache), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .err_len(err_len), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        s0_arid = '0; s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0; s0_arcache = '0;
        s1_arid = '0; s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0; s1_arcache = '0;
        s0_arvalid = 1'b0; s1_arvalid = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
        m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        exp_last = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        #1;
        n_checks++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL reset_arvalid got=%b want=0", m_arvalid); end
        n_checks++; if (m_araddr !== '0) begin n_err++; $display("FAIL reset_araddr got=%h want=0", m_araddr); end
        n_checks++; if (m_arid !== '0) begin n_err++; $display("FAIL reset_arid got=%h want=0", m_arid); end
        n_checks++; if (m_arlen !== 8'd0) begin n_err++; $display("FAIL reset_arlen got=%h want=0", m_arlen); end
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (err_len !== 1'b0) begin n_err++; $display("FAIL reset_err_len got=%b want=0", err_len); end
        n_checks++; if (m_rready !== 1'b0) begin n_err++; $display("FAIL reset_rready got=%b want=0", m_rready); end
        reset = 1'b0;
        exp_last = 1'b1;
        tick();
    endtask

    task automatic test_single;
        logic [DATA_W-1:0] d;
        clear_inputs();
        s0_arid = 4'hA; s0_araddr = 32'h1FC0_0000; s0_arlen = 8'd3; s0_arsize = 3'd2;
        s0_arburst = 2'b01; s0_arcache = 4'h3; s0_arvalid = 1'b1; m_arready = 1'b1;
        #1;
        n_checks++; if (s0_arready !== 1'b1) begin n_err++; $display("FAIL single_s0_arready got=%b want=1", s0_arready); end
        n_checks++; if (s1_arready !== 1'b0) begin n_err++; $display("FAIL single_s1_arready got=%b want=0", s1_arready); end
        n_checks++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL single_arvalid_early got=%b want=0", m_arvalid); end
        tick();
        s0_arvalid = 1'b0;
        #1;
        n_checks++; if (m_arvalid !== 1'b1) begin n_err++; $display("FAIL single_arvalid got=%b want=1", m_arvalid); end
        n_checks++; if (m_araddr !== 32'h1FC0_0000) begin n_err++; $display("FAIL single_araddr got=%h want=1fc00000", m_araddr); end
        n_checks++; if (m_arid !== 4'h2) begin n_err++; $display("FAIL single_arid got=%h want=2", m_arid); end
        n_checks++; if ({m_arlen, m_arsize, m_arburst, m_arcache} !== {8'd3, 3'd2, 2'b01, 4'h3}) begin
            n_err++; $display("FAIL single_payload got=%h/%h/%h/%h want=3/2/1/3", m_arlen, m_arsize, m_arburst, m_arcache); end
        n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got=%b want=1", busy); end
        tick();
        m_arready = 1'b0;
        #1;
        n_checks++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL single_arvalid_drop got=%b want=0", m_arvalid); end
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            m_rvalid = 1'b1; m_rdata = d; m_rlast = (i == 3); m_rid = 4'hA; m_rresp = 2'b00; s0_rready = 1'b1;
            #1;
            n_checks++; if (s0_rvalid !== 1'b1) begin n_err++; $display("FAIL single_rvalid beat%0d got=%b want=1", i, s0_rvalid); end
            n_checks++; if (s0_rdata !== d) begin n_err++; $display("FAIL single_rdata beat%0d got=%h want=%h", i, s0_rdata, d); end
            n_checks++; if (s0_rlast !== (i == 3)) begin n_err++; $display("FAIL single_rlast beat%0d got=%b want=%b", i, s0_rlast, (i == 3)); end
            n_checks++; if (s0_rid !== 4'h2) begin n_err++; $display("FAIL single_rid beat%0d got=%h want=2", i, s0_rid); end
            n_checks++; if (s1_rvalid !== 1'b0) begin n_err++; $display("FAIL single_s1_rvalid beat%0d got=%b want=0", i, s1_rvalid); end
            n_checks++; if (m_rready !== 1'b1) begin n_err++; $display("FAIL single_rready beat%0d got=%b want=1", i, m_rready); end
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; s0_rready = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end got=%b want=0", busy); end
        n_checks++; if (err_len !== 1'b0) begin n_err++; $display("FAIL single_err_len got=%b want=0", err_len); end
        exp_last = 1'b0;
    endtask

    task automatic test_tie;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            logic g;
            g = ~exp_last;
            s0_arid = 4'h1; s1_arid = 4'h5; s0_arlen = 8'd0; s1_arlen = 8'd0;
            s0_araddr = 32'h1000 + k; s1_araddr = 32'h2000 + k;
            s0_arvalid = 1'b1; s1_arvalid = 1'b1;
            #1;
            n_checks++; if (s0_arready !== ~g) begin n_err++; $display("FAIL tie%0d_s0_arready got=%b want=%b", k, s0_arready, ~g); end
            n_checks++; if (s1_arready !== g) begin n_err++; $display("FAIL tie%0d_s1_arready got=%b want=%b", k, s1_arready, g); end
            tick();
            s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_arready = 1'b1;
            #1;
            n_checks++; if (m_arid !== {g, (g ? 3'd5 : 3'd1)}) begin n_err++; $display("FAIL tie%0d_arid got=%h want=%h", k, m_arid, {g, (g ? 3'd5 : 3'd1)}); end
            n_checks++; if (m_araddr !== (g ? 32'h2000 + k : 32'h1000 + k)) begin n_err++; $display("FAIL tie%0d_araddr got=%h", k, m_araddr); end
            tick();
            m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = $urandom; s0_rready = 1'b1; s1_rready = 1'b1;
            #1;
            n_checks++; if ({s1_rvalid, s0_rvalid} !== (g ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL tie%0d_route got=%b%b", k, s1_rvalid, s0_rvalid); end
            tick();
            m_rvalid = 1'b0; m_rlast = 1'b0;
            exp_last = g;
        end
    endtask

    task automatic test_stall;
        clear_inputs();
        s0_arvalid = 1'b1; s0_araddr = 32'hCAFE_0040; s0_arlen = 8'd0; s0_arid = 4'h6;
        #1;
        n_checks++; if (s0_arready !== 1'b1) begin n_err++; $display("FAIL stall_s0_arready got=%b want=1", s0_arready); end
        tick();
        s0_arvalid = 1'b0; s1_arvalid = 1'b1; s1_araddr = 32'h5555_0000;
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; s0_rready = 1'b1; s1_rready = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            m_arready = (k == 5);
            #1;
            n_checks++; if (m_arvalid !== 1'b1) begin n_err++; $display("FAIL stall%0d_arvalid got=%b want=1", k, m_arvalid); end
            n_checks++; if (m_araddr !== 32'hCAFE_0040) begin n_err++; $display("FAIL stall%0d_araddr got=%h want=cafe0040", k, m_araddr); end
            n_checks++; if (s1_arready !== 1'b0) begin n_err++; $display("FAIL stall%0d_s1_arready got=%b want=0", k, s1_arready); end
            n_checks++; if ({s0_rvalid, s1_rvalid, m_rready} !== 3'b000) begin n_err++; $display("FAIL stall%0d_r_route got=%b%b%b want=000", k, s0_rvalid, s1_rvalid, m_rready); end
            tick();
        end
        s1_arvalid = 1'b0; m_arready = 1'b0; m_rlast = 1'b1;
        #1;
        n_checks++; if ({s0_rvalid, m_rready, s1_rvalid} !== 3'b110) begin n_err++; $display("FAIL stall_data got=%b%b%b want=110", s0_rvalid, m_rready, s1_rvalid); end
        tick();
        clear_inputs();
        exp_last = 1'b0;
    endtask

    task automatic test_rready_toggle;
        logic [DATA_W-1:0] dq[2];
        int idx;
        clear_inputs();
        s1_arvalid = 1'b1; s1_arid = 4'h3; s1_araddr = 32'h8000_0100; s1_arlen = 8'd1; m_arready = 1'b1;
        #1;
        n_checks++; if (s1_arready !== 1'b1) begin n_err++; $display("FAIL tog_s1_arready got=%b want=1", s1_arready); end
        tick();
        s1_arvalid = 1'b0;
        tick();
        m_arready = 1'b0;
        dq[0] = $urandom; dq[1] = $urandom; idx = 0;
        for (int c = 0; c < 3; c++) begin
            s1_rready = (c % 2 == 0);
            m_rvalid = 1'b1; m_rdata = dq[idx]; m_rlast = (idx == 1);
            #1;
            n_checks++; if (m_rready !== s1_rready) begin n_err++; $display("FAIL tog%0d_rready got=%b want=%b", c, m_rready, s1_rready); end
            n_checks++; if (s1_rdata !== dq[idx]) begin n_err++; $display("FAIL tog%0d_rdata got=%h want=%h", c, s1_rdata, dq[idx]); end
            n_checks++; if (s1_rvalid !== 1'b1) begin n_err++; $display("FAIL tog%0d_rvalid got=%b want=1", c, s1_rvalid); end
            tick();
            if (s1_rready) idx++;
        end
        s1_rready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL tog_busy got=%b want=0", busy); end
        n_checks++; if ({s1_rvalid, m_rready} !== 2'b00) begin n_err++; $display("FAIL tog_after got=%b%b want=00", s1_rvalid, m_rready); end
        n_checks++; if (err_len !== 1'b0) begin n_err++; $display("FAIL tog_err_len got=%b want=0", err_len); end
        clear_inputs();
        exp_last = 1'b1;
    endtask

    task automatic test_len_err;
        clear_inputs();
        s0_arvalid = 1'b1; s0_arlen = 8'd3; s0_araddr = 32'h40; m_arready = 1'b1;
        tick();
        s0_arvalid = 1'b0;
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b0; s0_rready = 1'b1;
        #1;
        n_checks++; if (err_len !== 1'b0) begin n_err++; $display("FAIL lenerr_early got=%b want=0", err_len); end
        tick();
        m_rlast = 1'b1;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        n_checks++; if (err_len !== 1'b1) begin n_err++; $display("FAIL lenerr_short got=%b want=1", err_len); end
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL lenerr_release got=%b want=0", busy); end
        tick(); tick();
        #1;
        n_checks++; if (err_len !== 1'b1) begin n_err++; $display("FAIL lenerr_sticky got=%b want=1", err_len); end
        do_reset();
        #1;
        n_checks++; if (err_len !== 1'b0) begin n_err++; $display("FAIL lenerr_cleared got=%b want=0", err_len); end
        s1_arvalid = 1'b1; s1_arlen = 8'd0; m_arready = 1'b1;
        tick();
        s1_arvalid = 1'b0;
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b0; s1_rready = 1'b1;
        tick();
        m_rvalid = 1'b0;
        #1;
        n_checks++; if (err_len !== 1'b1) begin n_err++; $display("FAIL lenerr_long got=%b want=1", err_len); end
        n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL lenerr_long_busy got=%b want=1", busy); end
        m_rvalid = 1'b1; m_rlast = 1'b1;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        n_checks++; if ({busy, err_len} !== 2'b01) begin n_err++; $display("FAIL lenerr_long_end got=%b%b want=01", busy, err_len); end
        do_reset();
    endtask

    task automatic test_reset_mid_data;
        clear_inputs();
        s0_arvalid = 1'b1; s0_arlen = 8'd3; s0_araddr = 32'h900; m_arready = 1'b1;
        tick();
        s0_arvalid = 1'b0;
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b0; s0_rready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b want=0", busy); end
        n_checks++; if (m_rready !== 1'b0) begin n_err++; $display("FAIL midrst_rready got=%b want=0", m_rready); end
        n_checks++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL midrst_arvalid got=%b want=0", m_arvalid); end
        n_checks++; if ({err_len, s0_rvalid} !== 2'b00) begin n_err++; $display("FAIL midrst_err_rvalid got=%b%b want=00", err_len, s0_rvalid); end
        clear_inputs();
        s1_arvalid = 1'b1; s1_arlen = 8'd0; s1_arid = 4'h7; s1_araddr = 32'h77;
        #1;
        n_checks++; if (s1_arready !== 1'b1) begin n_err++; $display("FAIL midrst_regrant got=%b want=1", s1_arready); end
        tick();
        s1_arvalid = 1'b0; m_arready = 1'b1;
        #1;
        n_checks++; if ({m_arvalid, m_arid} !== 5'h1F) begin n_err++; $display("FAIL midrst_ar got=%b/%h want=1/f", m_arvalid, m_arid); end
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1; s1_rready = 1'b1;
        #1;
        n_checks++; if (s1_rvalid !== 1'b1) begin n_err++; $display("FAIL midrst_rvalid got=%b want=1", s1_rvalid); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if ({busy, err_len} !== 2'b00) begin n_err++; $display("FAIL midrst_end got=%b%b want=00", busy, err_len); end
        exp_last = 1'b1;
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            int pat, stall, beat, cyc;
            logic g, v, rr;
            logic [3:0] id0, id1, rid, exp_id;
            logic [31:0] a0, a1, d, exp_addr;
            logic [7:0] l0, l1, len;
            clear_inputs();
            pat = int'($urandom_range(0, 2));
            stall = int'($urandom_range(0, 3));
            id0 = 4'($urandom); id1 = 4'($urandom);
            a0 = $urandom; a1 = $urandom;
            l0 = 8'($urandom_range(0, 3)); l1 = 8'($urandom_range(0, 3));
            g = (pat == 2) ? ~exp_last : (pat == 1);
            len = g ? l1 : l0;
            exp_addr = g ? a1 : a0;
            exp_id = {g, (g ? id1[2:0] : id0[2:0])};
            s0_arid = id0; s0_araddr = a0; s0_arlen = l0; s0_arvalid = (pat != 1);
            s1_arid = id1; s1_araddr = a1; s1_arlen = l1; s1_arvalid = (pat != 0);
            #1;
            n_checks++; if ({s1_arready, s0_arready} !== (g ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rnd%0d_grant got=%b%b want_g=%b", it, s1_arready, s0_arready, g); end
            tick();
            s0_arvalid = 1'b0; s1_arvalid = 1'b0;
            for (int k = 0; k <= stall; k++) begin
                m_arready = (k == stall);
                #1;
                n_checks++; if ({m_arvalid, m_araddr, m_arid, m_arlen} !== {1'b1, exp_addr, exp_id, len}) begin
                    n_err++; $display("FAIL rnd%0d_ar got=%b/%h/%h/%h want=1/%h/%h/%h", it, m_arvalid, m_araddr, m_arid, m_arlen, exp_addr, exp_id, len); end
                tick();
            end
            m_arready = 1'b0;
            beat = 0; cyc = 0; d = $urandom; rid = 4'($urandom);
            while (beat <= int'(len) && cyc < 64) begin
                v = ($urandom_range(0, 3) != 0);
                rr = 1'($urandom_range(0, 1));
                m_rvalid = v; m_rdata = d; m_rid = rid; m_rlast = (beat == int'(len));
                if (g) begin s1_rready = rr; s0_rready = 1'($urandom_range(0, 1)); end
                else   begin s0_rready = rr; s1_rready = 1'($urandom_range(0, 1)); end
                #1;
                n_checks++; if ({(g ? s1_rvalid : s0_rvalid), (g ? s0_rvalid : s1_rvalid), m_rready} !== {v, 1'b0, rr}) begin
                    n_err++; $display("FAIL rnd%0d_route got=%b%b%b want=%b0%b", it, (g ? s1_rvalid : s0_rvalid), (g ? s0_rvalid : s1_rvalid), m_rready, v, rr); end
                if (v) begin
                    n_checks++; if ({(g ? s1_rdata : s0_rdata), (g ? s1_rid : s0_rid)} !== {d, 1'b0, rid[2:0]}) begin
                        n_err++; $display("FAIL rnd%0d_beat%0d got=%h/%h want=%h/%h", it, beat, (g ? s1_rdata : s0_rdata), (g ? s1_rid : s0_rid), d, {1'b0, rid[2:0]}); end
                end
                tick();
                if (v && rr) begin
                    beat++;
                    d = $urandom; rid = 4'($urandom);
                end
                cyc++;
            end
            n_checks++; if (cyc >= 64) begin n_err++; $display("FAIL rnd%0d_timeout got=%0d beats want=%0d", it, beat, int'(len) + 1); end
            m_rvalid = 1'b0; m_rlast = 1'b0;
            #1;
            n_checks++; if ({busy, err_len} !== 2'b00) begin n_err++; $display("FAIL rnd%0d_end got=%b%b want=00", it, busy, err_len); end
            exp_last = g;
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        exp_last = 1'b1;
        reset    = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_tie();
        test_stall();
        test_rready_toggle();
        test_len_err();
        test_reset_mid_data();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
